ctrl_seq: RTL
=============

# ctrl_seq

Sequenced, parametrised control unit for the RV32I core. Like the single-cycle decoder it replaces, it decodes `opcode`/`func3`/`func7`/`b` into datapath selects. It also owns a multi-cycle state machine for LOAD and STORE, with a configurable memory latency. It stalls the program counter via `pc_en` and issues `mem_rd`/`mem_wr` strobes. It sits between the instruction register and the datapath muxes (`imm_mux`, `alu1_mux`, `alu2_mux`, `rd_mux`), `reg_file`, the PC and the data memory port.

## Interface
- `LOAD_LAT`, 2: memory cycles a LOAD occupies before write-back; must be ≥1.
- `STORE_LAT`, 1: memory cycles a STORE occupies; must be ≥1.
- `CNT_W`, 4: latency counter width; `LOAD_LAT` and `STORE_LAT` must each be < 2^CNT_W.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `opcode`  in  5  instruction bits [6:2].
- `func3`  in  3  instruction bits [14:12].
- `func7`  in  7  instruction bits [31:25].
- `b`  in  1  branch condition true, from the comparator.
- `mem_ack`  in  1  data memory done; used only with `CTRL_MEM_ACK_EN`.
- `imm_type`  out  3  immediate format: 000 none, 001 U, 010 J, 011 S, 100 I, 101 B.
- `alu1_sel`  out  1  ALU operand A: 1 = PC (JAL, BRANCH), 0 = rs1.
- `alu2_sel`  out  1  ALU operand B: 0 = rs2 (OP only), 1 = immediate.
- `alu_op`  out  4  ALU operation: {func7[5] when OP, or when OP_IMM with func3=101; else 0} concatenated with func3. It is 4'b0000 (add) for LOAD, STORE, LUI, JAL, JALR and BRANCH.
- `rd_sel`  out  2  write-back source: 10 ALU, 01 PC+4, 11 memory, 00 none.
- `reg_wr`  out  1  register file write enable.
- `pc_sel`  out  2  next-PC source: 00 PC+4, 01 branch target, 10 JAL target, 11 JALR target.
- `pc_en`  out  1  PC/instruction register advance enable.
- `mem_rd`  out  1  data memory read strobe.
- `mem_wr`  out  1  data memory write strobe.
- `illegal`  out  1  unsupported opcode in the current instruction.

## Operation
- Supported opcodes: OP 01100, OP_IMM 00100, LOAD 00000, STORE 01000, LUI 01101, JAL 11011, JALR 11001, BRANCH 11000. Any other opcode sets `illegal`=1 and is treated as a NOP: `reg_wr`=0, `pc_sel`=00, `pc_en`=1.
- `imm_type` per opcode:
  - LUI → U; JAL → J; STORE → S; BRANCH → B.
  - OP_IMM, LOAD, JALR → I.
  - OP and unsupported opcodes → none.
- `rd_sel` per opcode:
  - OP, OP_IMM, LUI → 10.
  - JAL, JALR → 01.
  - LOAD → 11.
  - STORE, BRANCH → 00.
- `pc_sel` per opcode:
  - BRANCH with `b`=1 → 01.
  - JAL → 10; JALR → 11.
  - Everything else → 00.
- FSM states are EXEC, MEM and WB. After reset the FSM is in EXEC.
- EXEC, non-memory opcode:
  - All decode outputs are combinational from the inputs.
  - `reg_wr`=1 for OP, OP_IMM, LUI, JAL, JALR; 0 otherwise.
  - `pc_en`=1; the FSM stays in EXEC.
- EXEC, LOAD or STORE:
  - Latch `opcode` and `func3` into `op_q`.
  - Assert `mem_rd` (LOAD) or `mem_wr` (STORE); drive `pc_en`=0 and `reg_wr`=0.
  - Load the counter with LAT-1, where LAT is `LOAD_LAT` for LOAD and `STORE_LAT` for STORE.
  - Next state: if the counter already ends (LAT=1), go to WB for LOAD or back to EXEC for STORE (with `pc_en`=1 in this cycle). Otherwise go to MEM.
- MEM:
  - Decode outputs come from `op_q`; input `opcode` is ignored.
  - The strobe stays high; `pc_en`=0.
  - The counter decrements each cycle. On the cycle the counter is 1: LOAD goes to WB; STORE drives `pc_en`=1 and returns to EXEC.
- WB (LOAD only): `reg_wr`=1, `rd_sel`=11, `mem_rd`=0, `pc_en`=1; the next state is EXEC.

## Timing
- Reset values: state=EXEC, counter=0, `op_q`=0.
- While `rst`=0, all outputs are 0: `pc_en`, `reg_wr`, `mem_rd`, `mem_wr`, `illegal`, and all selects.
- Non-memory instruction: 1 cycle.
- LOAD: `LOAD_LAT`+1 cycles, with `reg_wr` high only in the last cycle.
- STORE: `STORE_LAT` cycles, with `pc_en` high only in the last cycle.
- `mem_rd` and `mem_wr` are never high together, and never high in WB.
- Reset asserted mid-LOAD or mid-STORE returns the FSM to EXEC immediately; no `reg_wr` pulse is produced.
- Back-to-back LOADs: the cycle after WB is EXEC for the new instruction; there is no bubble.

## Configuration
- `CTRL_MEM_ACK_EN` defined:
  - MEM exits on `mem_ack`=1 sampled at the rising edge, instead of on the counter; LAT parameters and the counter are unused.
  - `mem_ack`=1 during EXEC completes the access in that cycle: LOAD goes to WB, STORE finishes with `pc_en`=1.
  - The wait is unbounded while `mem_ack`=0.
- Not defined: `mem_ack` is ignored and fixed latencies apply.

## Test plan
- Decode sweep at reset-release:
  - LUI → imm 001, rd 10, reg_wr 1.
  - OP_IMM → imm 100, alu2_sel 1.
  - STORE → imm 011, reg_wr 0.
  - OP → alu2_sel 0; 5'b10101 → illegal 1, reg_wr 0.
- BRANCH with b=0 → pc_sel 00; with b=1 → pc_sel 01, alu1_sel 1. JAL → pc_sel 10, rd_sel 01; JALR → pc_sel 11.
- LOAD with LOAD_LAT=2, opcode changed to OP in cycle 1:
  - mem_rd 1,1,0 and pc_en 0,0,1; reg_wr 1 and rd_sel 11 only in cycle 2.
  - The opcode change is ignored.
- STORE with STORE_LAT=1 → single cycle: mem_wr 1, pc_en 1, reg_wr 0. STORE followed by LOAD → no idle cycle.
- rst low during a LOAD's MEM cycle → all outputs 0 at once; after release, state is EXEC and no reg_wr pulse occurs.
- With `CTRL_MEM_ACK_EN`: LOAD with mem_ack held 0 for 5 cycles → pc_en stays 0; mem_ack 1 → WB on the next cycle with reg_wr 1.

Source files
------------

// File: rtl/ctrl_seq.sv
// Sequenced RV32I control unit: opcode decode plus an EXEC/MEM/WB machine for LOAD/STORE.
// Optional feature macro CTRL_MEM_ACK_EN: memory accesses end on mem_ack instead of a fixed latency.
module ctrl_seq #(
  parameter int LOAD_LAT  = 2,
  parameter int STORE_LAT = 1,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       b,
  input  logic       mem_ack,
  output logic [2:0] imm_type,
  output logic       alu1_sel,
  output logic       alu2_sel,
  output logic [3:0] alu_op,
  output logic [1:0] rd_sel,
  output logic       reg_wr,
  output logic [1:0] pc_sel,
  output logic       pc_en,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       illegal
);

  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;

  typedef enum logic [1:0] {EXEC, MEM, WB} state_t;

  state_t     state, state_nxt;
  logic [7:0] op_q;
  logic       mem_done;

  logic [4:0] opc_d;
  logic [2:0] f3_d;
  logic       f7b_d, b_d;

  logic [2:0] imm_c;
  logic       alu1_c, alu2_c, wr_ok, ill_c, is_load, is_store;
  logic [3:0] aop_c;
  logic [1:0] rd_c, ps_c;
  logic       reg_wr_c, pc_en_c, mem_rd_c, mem_wr_c;

  // Outside EXEC the latched LOAD/STORE drives decode; live inputs are ignored.
  always_comb begin
    opc_d = op_q[7:3];
    f3_d  = op_q[2:0];
    f7b_d = 1'b0;
    b_d   = 1'b0;
    if (state == EXEC) begin
      opc_d = opcode;
      f3_d  = func3;
      f7b_d = func7[5];
      b_d   = b;
    end
  end

  always_comb begin
    imm_c    = 3'b000;
    alu1_c   = 1'b0;
    alu2_c   = 1'b0;
    aop_c    = 4'b0000;
    rd_c     = 2'b00;
    ps_c     = 2'b00;
    wr_ok    = 1'b0;
    ill_c    = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    case (opc_d)
      OPC_OP: begin
        aop_c = {f7b_d, f3_d};
        rd_c  = 2'b10;
        wr_ok = 1'b1;
      end
      OPC_OP_IMM: begin
        imm_c  = 3'b100;
        alu2_c = 1'b1;
        aop_c  = {(f3_d == 3'b101) & f7b_d, f3_d};
        rd_c   = 2'b10;
        wr_ok  = 1'b1;
      end
      OPC_LOAD: begin
        imm_c   = 3'b100;
        alu2_c  = 1'b1;
        rd_c    = 2'b11;
        is_load = 1'b1;
      end
      OPC_STORE: begin
        imm_c    = 3'b011;
        alu2_c   = 1'b1;
        is_store = 1'b1;
      end
      OPC_LUI: begin
        imm_c  = 3'b001;
        alu2_c = 1'b1;
        rd_c   = 2'b10;
        wr_ok  = 1'b1;
      end
      OPC_JAL: begin
        imm_c  = 3'b010;
        alu1_c = 1'b1;
        alu2_c = 1'b1;
        rd_c   = 2'b01;
        ps_c   = 2'b10;
        wr_ok  = 1'b1;
      end
      OPC_JALR: begin
        imm_c  = 3'b100;
        alu2_c = 1'b1;
        rd_c   = 2'b01;
        ps_c   = 2'b11;
        wr_ok  = 1'b1;
      end
      OPC_BRANCH: begin
        imm_c  = 3'b101;
        alu1_c = 1'b1;
        alu2_c = 1'b1;
        ps_c   = b_d ? 2'b01 : 2'b00;
      end
      default: ill_c = 1'b1;
    endcase
  end

`ifdef CTRL_MEM_ACK_EN
  logic unused_in;
  assign unused_in = ^{func7[6], func7[4:0]};
  assign mem_done  = mem_ack;
`else
  logic             unused_in;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] lat_m1;

  assign unused_in = ^{func7[6], func7[4:0], mem_ack};
  assign lat_m1    = is_load ? CNT_W'(LOAD_LAT - 1) : CNT_W'(STORE_LAT - 1);
  assign mem_done  = (state == EXEC) ? (lat_m1 == '0) : (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_q <= '0;
    else if ((state == EXEC) && (is_load || is_store))
      cnt_q <= lat_m1;
    else if (state == MEM)
      cnt_q <= cnt_q - CNT_W'(1);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EXEC;
      op_q  <= '0;
    end else begin
      state <= state_nxt;
      if ((state == EXEC) && (is_load || is_store))
        op_q <= {opcode, func3};
    end
  end

  always_comb begin
    state_nxt = state;
    reg_wr_c  = 1'b0;
    pc_en_c   = 1'b0;
    mem_rd_c  = 1'b0;
    mem_wr_c  = 1'b0;
    case (state)
      EXEC: begin
        if (is_load || is_store) begin
          mem_rd_c = is_load;
          mem_wr_c = is_store;
          if (!mem_done)
            state_nxt = MEM;
          else if (is_load)
            state_nxt = WB;
          else
            pc_en_c = 1'b1;
        end else begin
          reg_wr_c = wr_ok;
          pc_en_c  = 1'b1;
        end
      end
      MEM: begin
        mem_rd_c = is_load;
        mem_wr_c = is_store;
        if (mem_done) begin
          if (is_load) begin
            state_nxt = WB;
          end else begin
            pc_en_c   = 1'b1;
            state_nxt = EXEC;
          end
        end
      end
      WB: begin
        reg_wr_c  = 1'b1;
        pc_en_c   = 1'b1;
        state_nxt = EXEC;
      end
      default: state_nxt = EXEC;
    endcase
  end

  // Every output is held low for as long as reset is asserted.
  always_comb begin
    imm_type = '0;
    alu1_sel = 1'b0;
    alu2_sel = 1'b0;
    alu_op   = '0;
    rd_sel   = '0;
    reg_wr   = 1'b0;
    pc_sel   = '0;
    pc_en    = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    illegal  = 1'b0;
    if (rst) begin
      imm_type = imm_c;
      alu1_sel = alu1_c;
      alu2_sel = alu2_c;
      alu_op   = aop_c;
      rd_sel   = rd_c;
      reg_wr   = reg_wr_c;
      pc_sel   = ps_c;
      pc_en    = pc_en_c;
      mem_rd   = mem_rd_c;
      mem_wr   = mem_wr_c;
      illegal  = ill_c;
    end
  end

endmodule
